// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side bus of the shared memory port arbiter
// Ports (signals):
//   fetch side : if_req, if_addr -> if_ack, if_rdata
//   data side  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   memory side: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status     : stall, busy, conflict_cnt
//   slave modport is the arbiter; master modport is the requesters plus memory
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              busy;
    logic [CNT_W-1:0]  conflict_cnt;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall, busy, conflict_cnt
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall, busy, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between fetch and load/store
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave carrying both requester handshakes, the memory
//              strobe/address/data, stall, busy and the saturating conflict counter
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [1:0] LAT_TOP = 2'(MEM_LAT - 1);
    state_t            state, state_nx;
    logic              last_d, grant_d, we_q, pick_d, first, done, if_ack_c, d_ack_c;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    // data wins unless it was granted last and fetch is also waiting
    assign pick_d   = bus.d_req & (~bus.if_req | ~last_d);
    assign first    = (state == ACCESS) && (lat_cnt == LAT_TOP);
    assign done     = (state == ACCESS) && (lat_cnt == 2'd0);
    assign if_ack_c = done & ~grant_d;
    assign d_ack_c  = done & grant_d;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE && (bus.if_req | bus.d_req))
            state_nx = ACCESS;
        else if (done)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d     <= 1'b0;
            grant_d    <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
        end else if (state == IDLE) begin
            if (bus.if_req | bus.d_req) begin
                grant_d <= pick_d;
                last_d  <= pick_d;
                addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                we_q    <= pick_d & bus.d_we;
                lat_cnt <= LAT_TOP;
                if (pick_d)
                    wdata_q <= bus.d_wdata;
                if (bus.if_req && bus.d_req && !(&cnt_q))
                    cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            lat_cnt <= lat_cnt - 2'd1;
            if (if_ack_c)
                if_rdata_q <= bus.mem_rdata;
            if (d_ack_c && !we_q)
                d_rdata_q <= bus.mem_rdata;
        end
    end
    // read data is forwarded in the ack cycle and held from the captured copy afterwards
    always_comb begin
        bus.mem_en       = first;
        bus.mem_we       = first & we_q;
        bus.mem_addr     = addr_q;
        bus.mem_wdata    = wdata_q;
        bus.if_ack       = if_ack_c;
        bus.d_ack        = d_ack_c;
        bus.if_rdata     = if_ack_c ? bus.mem_rdata : if_rdata_q;
        bus.d_rdata      = (d_ack_c & ~we_q) ? bus.mem_rdata : d_rdata_q;
        bus.busy         = state == ACCESS;
        bus.conflict_cnt = cnt_q;
        bus.stall        = (bus.if_req & ~if_ack_c) | (bus.d_req & ~d_ack_c);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the arbiter at MEM_LAT=2/CNT_W=16 and MEM_LAT=1/CNT_W=2
module tb_mem_port_arbiter;
    typedef struct {
        bit          d;
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst0, rst1;
    int          nchk = 0, nerr = 0;
    exp_t        q0[$], q1[$];
    exp_t        e0, e1;
    int          wr_cnt = 0, i_cyc = -1, d_cyc = -1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) b0();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2))  b1();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst0), .bus(b0));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(2))  u1 (.clk(clk), .rst(rst1), .bus(b1));
    // memory: 0x10 holds an instruction, one writable word, everything else a pattern
    assign b0.mem_rdata = (b0.mem_addr == 32'h10) ? 32'h00A00093 :
                          (wr_valid && b0.mem_addr == wr_addr) ? wr_data : {16'hA5A5, b0.mem_addr[17:2]};
    assign b1.mem_rdata = {16'hA5A5, b1.mem_addr[17:2]};
    always @(posedge clk) begin
        if (b0.mem_en && b0.mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= b0.mem_addr;
            wr_data  <= b0.mem_wdata;
            wr_cnt   <= wr_cnt + 1;
        end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (b0.if_ack || b0.d_ack) begin
            if (q0.size() == 0)
                chk("u0_unexpected_ack", {30'b0, b0.d_ack, b0.if_ack}, 32'h0);
            else begin
                e0 = q0.pop_front();
                chk("u0_ack_onehot", 32'(b0.if_ack & b0.d_ack), 32'h0);
                chk("u0_grant_is_d", 32'(b0.d_ack), 32'(e0.d));
                chk("u0_mem_addr", b0.mem_addr, e0.addr);
                chk("u0_rdata", e0.d ? b0.d_rdata : b0.if_rdata, e0.data);
                chk("u0_conflict_cnt", 32'(b0.conflict_cnt), e0.cnt);
            end
        end
    end
    always @(negedge clk) begin
        if (b1.if_ack || b1.d_ack) begin
            if (q1.size() == 0)
                chk("u1_unexpected_ack", {30'b0, b1.d_ack, b1.if_ack}, 32'h0);
            else begin
                e1 = q1.pop_front();
                chk("u1_grant_is_d", 32'(b1.d_ack), 32'(e1.d));
                chk("u1_mem_en_at_ack", 32'(b1.mem_en), 32'h1);
                chk("u1_mem_addr", b1.mem_addr, e1.addr);
                chk("u1_rdata", e1.d ? b1.d_rdata : b1.if_rdata, e1.data);
                chk("u1_conflict_cnt", 32'(b1.conflict_cnt), e1.cnt);
            end
        end
    end
    task automatic drive0(input int n, input bit reraise);
        int got = 0;
        int c = 0;
        bit ia, da;
        while (got < n && c < 200) begin
            @(negedge clk);
            ia = b0.if_ack;
            da = b0.d_ack;
            @(posedge clk);
            #1;
            if (ia) begin
                got++;
                i_cyc = c;
                if (reraise && got < n) b0.if_addr += 4;
                else b0.if_req = 1'b0;
            end
            if (da) begin
                got++;
                d_cyc = c;
                if (reraise && got < n) b0.d_addr += 4;
                else b0.d_req = 1'b0;
            end
            c++;
        end
        chk("u0_acks_seen", got, n);
        b0.if_req = 1'b0;
        b0.d_req  = 1'b0;
    endtask
    task automatic drive1(input int n);
        int got = 0;
        int c = 0;
        bit ia, da;
        while (got < n && c < 200) begin
            @(negedge clk);
            ia = b1.if_ack;
            da = b1.d_ack;
            @(posedge clk);
            #1;
            if (ia) begin
                got++;
                if (got < n) b1.if_addr += 4;
            end
            if (da) begin
                got++;
                if (got < n) b1.d_addr += 4;
            end
            c++;
        end
        chk("u1_acks_seen", got, n);
        b1.if_req = 1'b0;
        b1.d_req  = 1'b0;
    endtask
    task automatic seq0();
        @(posedge clk);
        #1;
        b0.if_req  = 1'b1;
        b0.if_addr = 32'h10;
        q0.push_back('{1'b0, 32'h10, 32'h00A00093, 0});
        @(negedge clk);
        chk("fetch_stall_c0", 32'(b0.stall), 32'h1);
        chk("fetch_busy_c0", 32'(b0.busy), 32'h0);
        @(negedge clk);
        chk("fetch_mem_en_c1", 32'(b0.mem_en), 32'h1);
        chk("fetch_mem_we_c1", 32'(b0.mem_we), 32'h0);
        chk("fetch_mem_addr_c1", b0.mem_addr, 32'h10);
        chk("fetch_busy_c1", 32'(b0.busy), 32'h1);
        chk("fetch_stall_c1", 32'(b0.stall), 32'h1);
        chk("fetch_if_ack_c1", 32'(b0.if_ack), 32'h0);
        @(negedge clk);
        chk("fetch_if_ack_c2", 32'(b0.if_ack), 32'h1);
        chk("fetch_mem_en_c2", 32'(b0.mem_en), 32'h0);
        chk("fetch_busy_c2", 32'(b0.busy), 32'h1);
        chk("fetch_stall_c2", 32'(b0.stall), 32'h0);
        @(posedge clk);
        #1;
        b0.if_req = 1'b0;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        b0.if_req  = 1'b1;
        b0.if_addr = 32'h20;
        b0.d_req   = 1'b1;
        b0.d_we    = 1'b0;
        b0.d_addr  = 32'h80;
        q0.push_back('{1'b1, 32'h80, 32'hA5A50020, 1});
        q0.push_back('{1'b0, 32'h20, 32'hA5A50008, 1});
        drive0(2, 1'b0);
        chk("dual_d_ack_cycle", d_cyc, 2);
        chk("dual_if_ack_cycle", i_cyc, 5);
        b0.if_req  = 1'b1;
        b0.if_addr = 32'h20;
        b0.d_req   = 1'b1;
        b0.d_addr  = 32'h80;
        q0.push_back('{1'b1, 32'h80, 32'hA5A50020, 2});
        q0.push_back('{1'b0, 32'h20, 32'hA5A50008, 3});
        q0.push_back('{1'b1, 32'h84, 32'hA5A50021, 4});
        q0.push_back('{1'b0, 32'h24, 32'hA5A50009, 5});
        drive0(4, 1'b1);
        b0.d_req   = 1'b1;
        b0.d_we    = 1'b1;
        b0.d_addr  = 32'h24;
        b0.d_wdata = 32'hDEADBEEF;
        q0.push_back('{1'b1, 32'h24, 32'hA5A50021, 5});
        drive0(1, 1'b0);
        b0.d_we = 1'b0;
        chk("store_write_cycles", wr_cnt, 1);
        chk("store_wdata", wr_data, 32'hDEADBEEF);
        b0.d_req  = 1'b1;
        b0.d_addr = 32'h24;
        q0.push_back('{1'b1, 32'h24, 32'hDEADBEEF, 5});
        drive0(1, 1'b0);
        b0.d_req  = 1'b1;
        b0.d_addr = 32'h40;
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_en_T", 32'(b0.mem_en), 32'h1);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        b0.d_req = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_en", 32'(b0.mem_en), 32'h0);
        chk("rstmid_mem_we", 32'(b0.mem_we), 32'h0);
        chk("rstmid_busy", 32'(b0.busy), 32'h0);
        chk("rstmid_d_ack", 32'(b0.d_ack), 32'h0);
        chk("rstmid_conflict_cnt", 32'(b0.conflict_cnt), 32'h0);
        chk("rstmid_d_rdata", b0.d_rdata, 32'h0);
        repeat (6) @(posedge clk);
    endtask
    task automatic seq1();
        @(posedge clk);
        #1;
        b1.if_req  = 1'b1;
        b1.if_addr = 32'h20;
        b1.d_req   = 1'b1;
        b1.d_we    = 1'b0;
        b1.d_addr  = 32'h80;
        q1.push_back('{1'b1, 32'h80, 32'hA5A50020, 1});
        q1.push_back('{1'b0, 32'h20, 32'hA5A50008, 2});
        q1.push_back('{1'b1, 32'h84, 32'hA5A50021, 3});
        q1.push_back('{1'b0, 32'h24, 32'hA5A50009, 3});
        q1.push_back('{1'b1, 32'h88, 32'hA5A50022, 3});
        drive1(5);
    endtask
    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("reset_mem_en", 32'(b0.mem_en), 32'h0);
        chk("reset_mem_we", 32'(b0.mem_we), 32'h0);
        chk("reset_mem_addr", b0.mem_addr, 32'h0);
        chk("reset_mem_wdata", b0.mem_wdata, 32'h0);
        chk("reset_acks", {30'b0, b0.if_ack, b0.d_ack}, 32'h0);
        chk("reset_if_rdata", b0.if_rdata, 32'h0);
        chk("reset_d_rdata", b0.d_rdata, 32'h0);
        chk("reset_busy", 32'(b0.busy), 32'h0);
        chk("reset_stall", 32'(b0.stall), 32'h0);
        chk("reset_conflict_cnt", 32'(b0.conflict_cnt), 32'h0);
        chk("reset_u1_conflict_cnt", 32'(b1.conflict_cnt), 32'h0);
        fork
            seq0();
            seq1();
        join
        @(negedge clk);
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch path (PC/IR side) and the load/store path (ALU address, rs2 write data) of the datapath.
- Sequences each access through a small FSM with a fixed memory latency.
- Returns a per-requester ack and read data, and produces a stall that holds the PC register while an access is outstanding.
- Resolves simultaneous requests round-robin and counts conflicts for performance analysis.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata, counting the mem_en cycle (legal range 1..4).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (level; held until if_ack).
- if_addr  in  ADDR_W  fetch address (PCOut).
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word (to IR).
- d_req  in  1  data request (level; held until d_ack).
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (ALUOut).
- d_wdata  in  DATA_W  store data (rs2Read).
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data (memoryOut).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack); combinational.
- busy  out  1  FSM not in IDLE.
- conflict_cnt  out  CNT_W  saturating count of grants made with both requests pending.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: FSM = IDLE; mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, busy, conflict_cnt all 0; last_grant = IF.
- States:
  - IDLE: no access in flight.
  - ACCESS: the latched request is being serviced.
- IDLE to ACCESS: at a rising edge with any request asserted.
  - Only d_req: grant D.
  - Only if_req: grant I.
  - Both: grant whichever is not last_grant, and increment conflict_cnt (saturates at all-ones).
  - At the same edge: latch addr/we/wdata of the winner (we forced 0 for I); set last_grant = winner; load lat_cnt = MEM_LAT-1.
- ACCESS timing:
  - mem_en = 1 only in the first ACCESS cycle (T).
  - mem_we = latched we in cycle T, else 0.
  - mem_addr and mem_wdata are driven from latched registers throughout ACCESS and hold their values afterwards.
  - lat_cnt decrements each cycle.
  - In cycle T+MEM_LAT-1 (lat_cnt = 0), the winner's ack = 1 for exactly one cycle.
  - For a load or fetch, the winner's rdata = mem_rdata combinationally in the ack cycle, and is also captured so it holds thereafter.
  - For a store, rdata is unchanged.
- ACCESS to IDLE: at the edge ending the ack cycle.
- Requester handshake: the requester deasserts req or presents a new request in the cycle after ack.
- Requests are sampled only in IDLE, so one access occupies MEM_LAT+1 cycles including the IDLE sampling cycle.
- Requests arriving during ACCESS wait; the losing request stays pending and is granted at the next IDLE edge.
- A request dropped before grant is ignored; no ack is produced.
- Address bits pass through unmodified; word alignment is the requester's responsibility.
- Reset in any cycle, including mid-ACCESS:
  - Next cycle is IDLE with all reset values.
  - mem_en and mem_we are 0 from the cycle after reset is sampled.
  - The in-flight access produces no ack.
- MEM_LAT = 1: mem_en and ack occur in the same cycle T.

Test Plan:
- MEM_LAT=2, fetch only:
  - Stimulus: if_req=1, if_addr=0x10 sampled at edge E0; memory returns 0x00A00093 in cycle 2.
  - Required: mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1; if_ack=1 and if_rdata=0x00A00093 in cycle 2; busy=1 in cycles 1-2; stall=1 in cycle 0 and cycle 1.
- MEM_LAT=2, simultaneous requests after reset:
  - Stimulus: if_req=1, addr 0x20; d_req=1, d_we=0, addr 0x80; both held until acked.
  - Required: data served first (mem_addr=0x80, d_ack in cycle 2); then fetch (mem_addr=0x20, if_ack in cycle 5); conflict_cnt=1.
- Continuous dual requests, re-raised immediately after each ack:
  - Required: grants alternate D, I, D, I; conflict_cnt increments on every grant.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x24, d_wdata=0xDEADBEEF.
  - Required: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF for exactly one cycle; d_ack one cycle; d_rdata keeps its prior value.
- Reset mid-access:
  - Stimulus: rst=1 in cycle T of a data load.
  - Required: next cycle has mem_en=0, FSM IDLE, no d_ack ever for that load, conflict_cnt=0, d_rdata=0.
- CNT_W=2, five consecutive conflicted grants:
  - Required: conflict_cnt reads 1, 2, 3, 3, 3 (saturates, no wrap).
